// File: rtl/tmu2_adrgen_pkg.sv
// Shared TMU2 constants and coordinate types used by the address generator.
package tmu2_adrgen_pkg;

  localparam int TMU2_FRAC_BITS   = 6;
  localparam int TMU2_COORD_BITS  = 11;
  localparam int TMU2_TCOORD_BITS = 17;
  localparam int TMU2_PROD_BITS   = 2 * TMU2_COORD_BITS;

  typedef logic [TMU2_COORD_BITS-1:0] coord_t;
  typedef logic [TMU2_FRAC_BITS-1:0]  frac_t;
  typedef logic [TMU2_PROD_BITS-1:0]  prod_t;

endpackage

// File: rtl/tmu2_mult11.sv
// 11x11 unsigned multiplier with a single clock-enabled output register (DSP friendly).
module tmu2_mult11
  import tmu2_adrgen_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   i_ce,
  input  coord_t i_a,
  input  coord_t i_b,
  output prod_t  o_p
);

  prod_t r_p;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p <= '0;
    end else if (i_ce) begin
      r_p <= {{TMU2_COORD_BITS{1'b0}}, i_a} * {{TMU2_COORD_BITS{1'b0}}, i_b};
    end
  end

  assign o_p = r_p;

endmodule

// File: rtl/tmu2_adrgen.sv
// TMU2 address generator: destination pixel address, four bilinear texel
// addresses and fractional weights, four-stage pipeline under a global stall.
module tmu2_adrgen
  import tmu2_adrgen_pkg::*;
#(
  parameter int fml_depth = 26
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  output logic                 busy,
  input  logic                 pipe_stb_i,
  output logic                 pipe_ack_o,
  input  logic [10:0]          dx_c,
  input  logic [10:0]          dy_c,
  input  logic [16:0]          tx_c,
  input  logic [16:0]          ty_c,
  input  logic [fml_depth-2:0] dst_fbuf,
  input  logic [10:0]          dst_hres,
  input  logic [fml_depth-2:0] tex_fbuf,
  input  logic [10:0]          tex_hres,
  output logic                 pipe_stb_o,
  input  logic                 pipe_ack_i,
  output logic [fml_depth-2:0] dadr,
  output logic [fml_depth-2:0] tadra,
  output logic [fml_depth-2:0] tadrb,
  output logic [fml_depth-2:0] tadrc,
  output logic [fml_depth-2:0] tadrd,
  output logic [5:0]           x_frac,
  output logic [5:0]           y_frac
);

  localparam int AW = fml_depth - 1;

  logic w_en;
  assign w_en       = ~pipe_stb_o | pipe_ack_i;
  assign pipe_ack_o = w_en;

  logic   r_v0, r_v1, r_v2;
  coord_t r_dx0, r_dy0, r_tx0, r_ty0, r_dx1, r_tx1;
  frac_t  r_xf0, r_yf0, r_xf1, r_yf1, r_xf2, r_yf2;
  prod_t  w_dmul, w_tmul;
  logic [AW-1:0] r_dadr2, r_ta2, r_ys2;
  logic          r_xs2;

  assign busy = r_v0 | r_v1 | r_v2 | pipe_stb_o;

  // S0: split texture coordinates into integer texel index and 6-bit weight
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_v0  <= 1'b0;
      r_dx0 <= '0;
      r_dy0 <= '0;
      r_tx0 <= '0;
      r_ty0 <= '0;
      r_xf0 <= '0;
      r_yf0 <= '0;
    end else if (w_en) begin
      r_v0  <= pipe_stb_i;
      r_dx0 <= dx_c;
      r_dy0 <= dy_c;
      r_tx0 <= tx_c[TMU2_TCOORD_BITS-1:TMU2_FRAC_BITS];
      r_ty0 <= ty_c[TMU2_TCOORD_BITS-1:TMU2_FRAC_BITS];
      r_xf0 <= tx_c[TMU2_FRAC_BITS-1:0];
      r_yf0 <= ty_c[TMU2_FRAC_BITS-1:0];
    end
  end

  tmu2_mult11 u_dmul (
    .clk  (sys_clk),
    .rst  (sys_rst),
    .i_ce (w_en),
    .i_a  (r_dy0),
    .i_b  (dst_hres),
    .o_p  (w_dmul)
  );

  tmu2_mult11 u_tmul (
    .clk  (sys_clk),
    .rst  (sys_rst),
    .i_ce (w_en),
    .i_a  (r_ty0),
    .i_b  (tex_hres),
    .o_p  (w_tmul)
  );

  // S1: row products live in the multipliers; side data rides alongside
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_v1  <= 1'b0;
      r_dx1 <= '0;
      r_tx1 <= '0;
      r_xf1 <= '0;
      r_yf1 <= '0;
    end else if (w_en) begin
      r_v1  <= r_v0;
      r_dx1 <= r_dx0;
      r_tx1 <= r_tx0;
      r_xf1 <= r_xf0;
      r_yf1 <= r_yf0;
    end
  end

  // S2: base addresses; zero-weight neighbours collapse onto texel A
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_v2    <= 1'b0;
      r_dadr2 <= '0;
      r_ta2   <= '0;
      r_xs2   <= 1'b0;
      r_ys2   <= '0;
      r_xf2   <= '0;
      r_yf2   <= '0;
    end else if (w_en) begin
      r_v2    <= r_v1;
      r_dadr2 <= dst_fbuf + AW'(w_dmul) + AW'(r_dx1);
      r_ta2   <= tex_fbuf + AW'(w_tmul) + AW'(r_tx1);
      r_xs2   <= (r_xf1 != '0);
      r_ys2   <= (r_yf1 != '0) ? AW'(tex_hres) : '0;
      r_xf2   <= r_xf1;
      r_yf2   <= r_yf1;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      pipe_stb_o <= 1'b0;
      dadr       <= '0;
      tadra      <= '0;
      tadrb      <= '0;
      tadrc      <= '0;
      tadrd      <= '0;
      x_frac     <= '0;
      y_frac     <= '0;
    end else if (w_en) begin
      pipe_stb_o <= r_v2;
      dadr       <= r_dadr2;
      tadra      <= r_ta2;
      tadrb      <= r_ta2 + AW'(r_xs2);
      tadrc      <= r_ta2 + r_ys2;
      tadrd      <= r_ta2 + r_ys2 + AW'(r_xs2);
      x_frac     <= r_xf2;
      y_frac     <= r_yf2;
    end
  end

endmodule

// File: tb/tb_tmu2_adrgen.sv
// Directed and scoreboarded checks of tmu2_adrgen addresses, latency, stall and reset.
module tb_tmu2_adrgen;

  logic        sys_clk, sys_rst, busy, pipe_stb_i, pipe_ack_o, pipe_stb_o, pipe_ack_i;
  logic [10:0] dx_c, dy_c, dst_hres, tex_hres;
  logic [16:0] tx_c, ty_c;
  logic [24:0] dst_fbuf, tex_fbuf, dadr, tadra, tadrb, tadrc, tadrd;
  logic [5:0]  x_frac, y_frac;

  tmu2_adrgen #(.fml_depth(26)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .busy(busy),
    .pipe_stb_i(pipe_stb_i), .pipe_ack_o(pipe_ack_o),
    .dx_c(dx_c), .dy_c(dy_c), .tx_c(tx_c), .ty_c(ty_c),
    .dst_fbuf(dst_fbuf), .dst_hres(dst_hres), .tex_fbuf(tex_fbuf), .tex_hres(tex_hres),
    .pipe_stb_o(pipe_stb_o), .pipe_ack_i(pipe_ack_i),
    .dadr(dadr), .tadra(tadra), .tadrb(tadrb), .tadrc(tadrc), .tadrd(tadrd),
    .x_frac(x_frac), .y_frac(y_frac)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [24:0] d, a, b, c, dd;
    logic [5:0]  xf, yf;
  } exp_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned cyc = 0;
  int unsigned acc_cnt = 0;
  int unsigned out_cnt = 0;
  int unsigned win_base = 0;
  int unsigned first_cyc = 0;
  int unsigned last_cyc = 0;
  exp_t        q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [10:0] dx, input logic [10:0] dy,
                                 input logic [16:0] tx, input logic [16:0] ty);
    exp_t        m;
    logic [63:0] s;
    logic [63:0] ti, tj;
    s    = dst_fbuf + dy * dst_hres + dx;
    m.d  = s[24:0];
    ti   = tx >> 6;
    tj   = ty >> 6;
    s    = tex_fbuf + tj * tex_hres + ti;
    m.a  = s[24:0];
    m.xf = tx[5:0];
    m.yf = ty[5:0];
    s    = m.a + ((m.xf != 0) ? 64'd1 : 64'd0);
    m.b  = s[24:0];
    s    = m.a + ((m.yf != 0) ? 64'(tex_hres) : 64'd0);
    m.c  = s[24:0];
    s    = m.a + ((m.xf != 0) ? 64'd1 : 64'd0) + ((m.yf != 0) ? 64'(tex_hres) : 64'd0);
    m.dd = s[24:0];
    return m;
  endfunction

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Inputs change #1 after posedge, so at negedge they show what the next edge will transfer.
  always @(negedge sys_clk) begin
    if (!sys_rst) begin
      if (pipe_stb_o && pipe_ack_i) begin
        if (q.size() == 0) begin
          chk("unexpected_out", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          $display("[TB] out %0d dadr=%h a=%h b=%h c=%h d=%h xf=%0d yf=%0d",
                   out_cnt, dadr, tadra, tadrb, tadrc, tadrd, x_frac, y_frac);
          chk("sb_dadr", dadr, e.d);
          chk("sb_tadra", tadra, e.a);
          chk("sb_tadrb", tadrb, e.b);
          chk("sb_tadrc", tadrc, e.c);
          chk("sb_tadrd", tadrd, e.dd);
          chk("sb_xfrac", x_frac, e.xf);
          chk("sb_yfrac", y_frac, e.yf);
        end
        if (out_cnt == win_base) first_cyc = cyc;
        last_cyc = cyc;
        out_cnt++;
      end
      if (pipe_stb_i && pipe_ack_o) begin
        q.push_back(model(dx_c, dy_c, tx_c, ty_c));
        acc_cnt++;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of the cycle the item appears.
  task automatic send_one(input logic [10:0] dx, input logic [10:0] dy,
                          input logic [16:0] tx, input logic [16:0] ty);
    int lat;
    dx_c = dx; dy_c = dy; tx_c = tx; ty_c = ty;
    pipe_stb_i = 1'b1;
    @(posedge sys_clk); #1;
    pipe_stb_i = 1'b0;
    lat = 1;
    while (!pipe_stb_o && lat < 20) begin
      @(posedge sys_clk); #1;
      lat++;
    end
    chk("latency", lat, 4);
  endtask

  initial begin
    sys_rst = 1'b0; pipe_stb_i = 1'b0; pipe_ack_i = 1'b1;
    dx_c = '0; dy_c = '0; tx_c = '0; ty_c = '0;
    dst_fbuf = 25'h100000; dst_hres = 11'd640;
    tex_fbuf = 25'h200000; tex_hres = 11'd512;
    #1 sys_rst = 1'b1;
    #1;
    chk("rst_stb_o", pipe_stb_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dadr", dadr, 0);
    chk("rst_tadrd", tadrd, 0);
    chk("rst_ack_o", pipe_ack_o, 1);
    repeat (2) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    @(posedge sys_clk); #1;

    send_one(11'd10, 11'd2, 17'd320, 17'd192);
    chk("dst_dadr", dadr, 25'h10050A);
    chk("zf_tadra", tadra, 25'h200605);
    chk("zf_tadrb", tadrb, 25'h200605);
    chk("zf_tadrc", tadrc, 25'h200605);
    chk("zf_tadrd", tadrd, 25'h200605);

    send_one(11'd10, 11'd2, 17'd352, 17'd208);
    chk("bl_tadra", tadra, 25'h200605);
    chk("bl_tadrb", tadrb, 25'h200606);
    chk("bl_tadrc", tadrc, 25'h200805);
    chk("bl_tadrd", tadrd, 25'h200806);
    chk("bl_xfrac", x_frac, 6'd32);
    chk("bl_yfrac", y_frac, 6'd16);

    send_one(11'd0, 11'd0, 17'd32704, 17'd192);
    chk("edge_tadra", tadra, 25'h2007FF);
    chk("edge_tadrb", tadrb, 25'h2007FF);
    chk("edge_tadrc", tadrc, 25'h2007FF);
    chk("edge_tadrd", tadrd, 25'h2007FF);

    send_one(11'd0, 11'd0, 17'd32704, 17'd208);
    chk("redge_tadrb", tadrb, 25'h2007FF);
    chk("redge_tadrc", tadrc, 25'h2009FF);
    chk("redge_tadrd", tadrd, 25'h2009FF);

    @(posedge sys_clk); #1;
    dst_fbuf = 25'h1FFFFFF;
    send_one(11'd1, 11'd0, 17'd0, 17'd0);
    chk("wrap_dadr", dadr, 25'h0);
    @(posedge sys_clk); #1;
    dst_fbuf = 25'h100000;

    // Back-pressure: six offered, four fit
    repeat (2) @(posedge sys_clk); #1;
    pipe_ack_i = 1'b0;
    win_base = out_cnt;
    begin
      int unsigned a0;
      a0 = acc_cnt;
      for (int i = 0; i < 6; i++) begin
        dx_c = 11'(i + 1); dy_c = 11'(i + 3);
        tx_c = 17'(i * 70 + 5); ty_c = 17'(i * 97);
        pipe_stb_i = 1'b1;
        @(posedge sys_clk); #1;
      end
      pipe_stb_i = 1'b0;
      chk("bp_accepted", acc_cnt - a0, 4);
    end
    chk("bp_ack_o", pipe_ack_o, 0);
    chk("bp_busy", busy, 1);
    repeat (3) @(posedge sys_clk); #1;
    chk("bp_no_out", out_cnt - win_base, 0);
    pipe_ack_i = 1'b1;
    for (int k = 0; k < 20 && q.size() != 0; k++) @(posedge sys_clk);
    #1;
    chk("bp_drained", out_cnt - win_base, 4);
    chk("bp_span", last_cyc - first_cyc, 3);
    chk("bp_busy_end", busy, 0);

    // Throughput: 100 back-to-back items
    @(posedge sys_clk); #1;
    win_base = out_cnt;
    for (int i = 0; i < 100; i++) begin
      dx_c = 11'($urandom_range(0, 2047));
      dy_c = 11'($urandom_range(0, 2047));
      tx_c = 17'($urandom_range(0, 131071));
      ty_c = 17'($urandom_range(0, 131071));
      if (i % 4 == 1) tx_c[5:0] = 6'd0;
      if (i % 5 == 2) ty_c[5:0] = 6'd0;
      pipe_stb_i = 1'b1;
      @(posedge sys_clk); #1;
      chk("tp_ack_o", pipe_ack_o, 1);
    end
    pipe_stb_i = 1'b0;
    for (int k = 0; k < 20 && (out_cnt - win_base) < 100; k++) @(posedge sys_clk);
    #1;
    chk("tp_count", out_cnt - win_base, 100);
    chk("tp_span", last_cyc - first_cyc, 99);
    chk("tp_queue", q.size(), 0);

    // Reset with three items in flight
    @(posedge sys_clk); #1;
    win_base = out_cnt;
    for (int i = 0; i < 3; i++) begin
      dx_c = 11'(i); dy_c = 11'(i + 1); tx_c = 17'(i * 64 + 3); ty_c = 17'(i * 64 + 7);
      pipe_stb_i = 1'b1;
      @(posedge sys_clk); #1;
    end
    pipe_stb_i = 1'b0;
    @(posedge sys_clk); #1;
    chk("rm_stb_before", pipe_stb_o, 1);
    chk("rm_busy_before", busy, 1);
    sys_rst = 1'b1;
    q.delete();
    #1;
    chk("rm_stb_async", pipe_stb_o, 0);
    chk("rm_busy_async", busy, 0);
    repeat (2) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    win_base = out_cnt;
    begin
      int stale;
      stale = 0;
      for (int i = 0; i < 6; i++) begin
        @(posedge sys_clk); #1;
        if (pipe_stb_o) stale++;
      end
      chk("rm_no_stale", stale, 0);
    end
    chk("rm_busy_after", busy, 0);
    send_one(11'd10, 11'd2, 17'd352, 17'd208);
    chk("rm_dadr", dadr, 25'h10050A);
    chk("rm_tadrd", tadrd, 25'h200806);
    repeat (3) @(posedge sys_clk); #1;
    chk("final_queue", q.size(), 0);
    chk("final_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
